// File: rtl/gate_seq_gen.sv
// gate_seq_gen: multi-channel gate window generator driven by the laser period counter.
// Each channel k is high while rise_k <= laser_cnt_in < fall_k.
// The window start moves per period with a swept index and a per-channel skew.
// Configuration is shadowed at frame boundaries.
//
// Sweep direction (triangle mode only):
//   state    | meaning
//   DIR_UP   | index counting towards M
//   DIR_DOWN | index counting towards 0
module gate_seq_gen #(
   parameter int CNT_W  = 32,
   parameter int NUM_CH = 10,
   parameter int IDX_W  = 8,
   parameter int STEP_W = 8,
   parameter int SKEW_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CNT_W-1:0]  laser_cnt_in,
   input  logic [CNT_W-1:0]  laser_freq,
   input  logic [CNT_W-1:0]  delay_a,
   input  logic [CNT_W-1:0]  width_a,
   input  logic [CNT_W-1:0]  delay_b,
   input  logic [CNT_W-1:0]  width_b,
   input  logic [IDX_W-1:0]  tim_cycles_m,
   input  logic [STEP_W-1:0] delay_step,
   input  logic [SKEW_W-1:0] ch_skew,
   input  logic [1:0]        sweep_mode,
   input  logic [1:0]        frame_type,
   output logic [NUM_CH-1:0] gate_out,
   output logic [IDX_W-1:0]  sweep_idx,
   output logic              sat_flag
);

   typedef enum logic [1:0] {
      MODE_FIXED = 2'd0,
      MODE_UP    = 2'd1,
      MODE_DOWN  = 2'd2,
      MODE_TRI   = 2'd3
   } mode_e;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   localparam logic [1:0] FRAME_A = 2'd1;
   localparam logic [1:0] FRAME_B = 2'd2;

   // Window sums are carried wide enough that a clamp can be detected.
   localparam int               EXT_W   = CNT_W + IDX_W + 1;
   localparam logic [EXT_W-1:0] CNT_MAX = EXT_W'({CNT_W{1'b1}});

   logic [1:0]        frame_q;
   logic              loaded_q;
   logic [CNT_W-1:0]  delay_sh_q, delay_sh_d;
   logic [CNT_W-1:0]  width_sh_q, width_sh_d;
   logic [IDX_W-1:0]  m_sh_q, m_sh_d;
   logic [STEP_W-1:0] step_sh_q, step_sh_d;
   logic [SKEW_W-1:0] skew_sh_q, skew_sh_d;
   mode_e             mode_sh_q, mode_sh_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   dir_e              dir_q, dir_d;
   logic [CNT_W-1:0]  rise_q [NUM_CH];
   logic [CNT_W-1:0]  rise_d [NUM_CH];
   logic [CNT_W-1:0]  fall_q [NUM_CH];
   logic [CNT_W-1:0]  fall_d [NUM_CH];
   logic [EXT_W-1:0]  rise_ext [NUM_CH];
   logic [EXT_W-1:0]  fall_ext [NUM_CH];
   logic              sat_new;
   logic              sat_q;
   logic [NUM_CH-1:0] gate_q, gate_d;
   logic              hit;
   logic              frame_change;
   logic              load_sh;
   logic              frame_ab_q;

   assign hit          = (laser_cnt_in >= laser_freq);
   assign frame_change = (frame_type != frame_q);
   // The first cycle out of reset captures the live configuration like a frame boundary.
   assign load_sh      = frame_change | ~loaded_q;
   assign frame_ab_q   = (frame_q == FRAME_A) || (frame_q == FRAME_B);

   // Shadow configuration: capture live inputs at a frame boundary, hold otherwise.
   always_comb begin
      delay_sh_d = delay_sh_q;
      width_sh_d = width_sh_q;
      m_sh_d     = m_sh_q;
      step_sh_d  = step_sh_q;
      skew_sh_d  = skew_sh_q;
      mode_sh_d  = mode_sh_q;
      if (load_sh) begin
         m_sh_d    = tim_cycles_m;
         step_sh_d = delay_step;
         skew_sh_d = ch_skew;
         mode_sh_d = mode_e'(sweep_mode);
         case (frame_type)
            FRAME_A: begin
               delay_sh_d = delay_a;
               width_sh_d = width_a;
            end
            FRAME_B: begin
               delay_sh_d = delay_b;
               width_sh_d = width_b;
            end
            default: begin
               delay_sh_d = '0;
               width_sh_d = '0;
            end
         endcase
      end
   end

   // Sweep index next state; a frame boundary restarts the sweep and wins over a hit.
   always_comb begin
      idx_d = idx_q;
      dir_d = dir_q;
      if (load_sh) begin
         idx_d = (mode_sh_d == MODE_DOWN) ? m_sh_d : '0;
         dir_d = DIR_UP;
      end else if (hit) begin
         case (mode_sh_q)
            MODE_FIXED: idx_d = '0;
            MODE_UP:    idx_d = (idx_q >= m_sh_q) ? '0 : idx_q + 1'b1;
            MODE_DOWN:  idx_d = (idx_q == '0) ? m_sh_q : idx_q - 1'b1;
            MODE_TRI: begin
               if (m_sh_q == '0) begin
                  idx_d = '0;
                  dir_d = DIR_UP;
               end else if (dir_q == DIR_UP) begin
                  if (idx_q < m_sh_q) begin
                     idx_d = idx_q + 1'b1;
                  end else begin
                     idx_d = idx_q - 1'b1;
                     dir_d = DIR_DOWN;
                  end
               end else begin
                  if (idx_q > '0) begin
                     idx_d = idx_q - 1'b1;
                  end else begin
                     idx_d = idx_q + 1'b1;
                     dir_d = DIR_UP;
                  end
               end
            end
            default: idx_d = '0;
         endcase
      end
   end

   // Window bounds from the index and shadows that take effect at this edge, clamped at full scale.
   always_comb begin
      sat_new = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         rise_ext[k] = EXT_W'(delay_sh_d)
                     + EXT_W'(idx_d) * EXT_W'(step_sh_d)
                     + EXT_W'(k) * EXT_W'(skew_sh_d);
         fall_ext[k] = rise_ext[k] + EXT_W'(width_sh_d);
         rise_d[k]   = (rise_ext[k] > CNT_MAX) ? {CNT_W{1'b1}} : rise_ext[k][CNT_W-1:0];
         fall_d[k]   = (fall_ext[k] > CNT_MAX) ? {CNT_W{1'b1}} : fall_ext[k][CNT_W-1:0];
         if ((rise_ext[k] > CNT_MAX) || (fall_ext[k] > CNT_MAX)) begin
            sat_new = 1'b1;
         end
      end
   end

   // Window compare; a window starting at or past the terminal count never opens.
   always_comb begin
      gate_d = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         gate_d[k] = frame_ab_q && !frame_change
                     && (laser_cnt_in >= rise_q[k])
                     && (laser_cnt_in < fall_q[k])
                     && (rise_q[k] < laser_freq);
      end
   end

   // State registers: shadows, sweep, windows, sticky saturation and the gate vector.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_q    <= '0;
         loaded_q   <= 1'b0;
         delay_sh_q <= '0;
         width_sh_q <= '0;
         m_sh_q     <= '0;
         step_sh_q  <= '0;
         skew_sh_q  <= '0;
         mode_sh_q  <= MODE_FIXED;
         idx_q      <= '0;
         dir_q      <= DIR_UP;
         sat_q      <= 1'b0;
         gate_q     <= '0;
         for (int k = 0; k < NUM_CH; k++) begin
            rise_q[k] <= '0;
            fall_q[k] <= '0;
         end
      end else begin
         frame_q    <= frame_type;
         loaded_q   <= 1'b1;
         delay_sh_q <= delay_sh_d;
         width_sh_q <= width_sh_d;
         m_sh_q     <= m_sh_d;
         step_sh_q  <= step_sh_d;
         skew_sh_q  <= skew_sh_d;
         mode_sh_q  <= mode_sh_d;
         idx_q      <= idx_d;
         dir_q      <= dir_d;
         if (load_sh || hit) begin
            for (int k = 0; k < NUM_CH; k++) begin
               rise_q[k] <= rise_d[k];
               fall_q[k] <= fall_d[k];
            end
         end
         if (load_sh) begin
            sat_q <= sat_new;
         end else if (hit) begin
            sat_q <= sat_q | sat_new;
         end
         gate_q <= gate_d;
      end
   end

   assign gate_out  = gate_q;
   assign sweep_idx = idx_q;
   assign sat_flag  = sat_q;

endmodule

// File: tb/tb_gate_seq_gen.sv
// tb_gate_seq_gen: scoreboard bench for gate_seq_gen.
// Expected gate/index/saturation values are queued as each counter value is driven.
// Each scenario task then pops the queue and compares it against what the DUT produced.
module tb_gate_seq_gen;

   localparam int     NCH  = 10;
   localparam longint MAXV = 64'h0000_0000_FFFF_FFFF;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [31:0]     laser_cnt_in, laser_freq;
   logic [31:0]     delay_a, width_a, delay_b, width_b;
   logic [7:0]      tim_cycles_m, delay_step;
   logic [15:0]     ch_skew;
   logic [1:0]      sweep_mode, frame_type;
   logic [NCH-1:0]  gate_out;
   logic [7:0]      sweep_idx;
   logic            sat_flag;

   typedef struct packed {
      logic [NCH-1:0] gate;
      logic [7:0]     idx;
      logic           sat;
   } obs_t;

   obs_t  exp_q [$];
   obs_t  obs_q [$];
   string tag_q [$];
   int    n_tests = 0;
   int    n_fail  = 0;

   gate_seq_gen #(
      .CNT_W  (32),
      .NUM_CH (NCH),
      .IDX_W  (8),
      .STEP_W (8),
      .SKEW_W (16)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .laser_cnt_in (laser_cnt_in),
      .laser_freq   (laser_freq),
      .delay_a      (delay_a),
      .width_a      (width_a),
      .delay_b      (delay_b),
      .width_b      (width_b),
      .tim_cycles_m (tim_cycles_m),
      .delay_step   (delay_step),
      .ch_skew      (ch_skew),
      .sweep_mode   (sweep_mode),
      .frame_type   (frame_type),
      .gate_out     (gate_out),
      .sweep_idx    (sweep_idx),
      .sat_flag     (sat_flag)
   );

   always #5 clk = ~clk;

   function automatic obs_t mk(input logic [NCH-1:0] g, input int ix, input bit s);
      obs_t r;
      r.gate = g;
      r.idx  = ix[7:0];
      r.sat  = s;
      return r;
   endfunction

   // Expected gate vector for counter value c with the window of the current period.
   function automatic logic [NCH-1:0] model_gate(input longint c, input longint dly,
                                                 input longint idx, input longint step,
                                                 input longint skew, input longint wid,
                                                 input longint freq, input bit ab);
      logic [NCH-1:0] g;
      longint r, f;
      g = '0;
      if (!ab) return g;
      for (int k = 0; k < NCH; k++) begin
         r = dly + idx * step + longint'(k) * skew;
         f = r + wid;
         if (r > MAXV) r = MAXV;
         if (f > MAXV) f = MAXV;
         g[k] = (c >= r) && (c < f) && (r < freq);
      end
      return g;
   endfunction

   // Drive one counter value, queue its expectation, capture the DUT response 1 ns after the edge.
   task automatic cyc(input longint c, input obs_t e, input string tag);
      obs_t o;
      laser_cnt_in = c[31:0];
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      o.gate = gate_out;
      o.idx  = sweep_idx;
      o.sat  = sat_flag;
      obs_q.push_back(o);
   endtask

   task automatic set_cfg(input logic [31:0] da, input logic [31:0] wa,
                          input logic [31:0] db, input logic [31:0] wb,
                          input int m, input int step, input int skew,
                          input int mode, input int freq);
      delay_a      = da;
      width_a      = wa;
      delay_b      = db;
      width_b      = wb;
      tim_cycles_m = m[7:0];
      delay_step   = step[7:0];
      ch_skew      = skew[15:0];
      sweep_mode   = mode[1:0];
      laser_freq   = freq[31:0];
   endtask

   task automatic do_reset(input longint c, input int n);
      rst_n = 1'b0;
      repeat (n) cyc(c, mk('0, 0, 1'b0), $sformatf("reset cnt=%0d", c));
      rst_n = 1'b1;
   endtask

   task automatic start_frame(input logic [1:0] ft, input longint c, input int idx0, input bit sat);
      frame_type = ft;
      cyc(c, mk('0, idx0, sat), $sformatf("frame->%0d cnt=%0d", ft, c));
   endtask

   task automatic run_period(input int idx_now, input int idx_next,
                             input longint dly, input longint step,
                             input longint skew, input longint wid,
                             input bit ab, input bit sat,
                             input int c_lo, input int c_hi);
      logic [NCH-1:0] g;
      int             ix;
      for (int c = c_lo; c <= c_hi; c++) begin
         g  = model_gate(c, dly, idx_now, step, skew, wid, longint'(laser_freq), ab);
         ix = (longint'(c) >= longint'(laser_freq)) ? idx_next : idx_now;
         cyc(c, mk(g, ix, sat), $sformatf("f%0d idx=%0d cnt=%0d", frame_type, idx_now, c));
      end
   endtask

   task automatic test_reset;
      obs_t e, o;
      string t;
      set_cfg(32'd10, 32'd5, 32'd0, 32'd0, 3, 7, 0, 0, 99);
      frame_type = 2'd1;
      do_reset(12, 3);
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL test_reset %s: got gate=%h idx=%0d sat=%b, want gate=%h idx=%0d sat=%b",
                     t, o.gate, o.idx, o.sat, e.gate, e.idx, e.sat);
         end
      end
   endtask

   task automatic test_fixed;
      obs_t e, o;
      string t;
      set_cfg(32'd10, 32'd5, 32'd0, 32'd0, 3, 7, 0, 0, 99);
      frame_type = 2'd0;
      do_reset(0, 2);
      start_frame(2'd1, 0, 0, 1'b0);
      repeat (2) run_period(0, 0, 10, 7, 0, 5, 1'b1, 1'b0, 0, 99);
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL test_fixed %s: got gate=%h idx=%0d sat=%b, want gate=%h idx=%0d sat=%b",
                     t, o.gate, o.idx, o.sat, e.gate, e.idx, e.sat);
         end
      end
   endtask

   task automatic test_sweep_up;
      obs_t e, o;
      string t;
      int seq [5] = '{0, 1, 2, 0, 1};
      set_cfg(32'd10, 32'd3, 32'd0, 32'd0, 2, 4, 0, 1, 29);
      frame_type = 2'd0;
      do_reset(0, 2);
      start_frame(2'd1, 0, 0, 1'b0);
      for (int p = 0; p < 4; p++) run_period(seq[p], seq[p+1], 10, 4, 0, 3, 1'b1, 1'b0, 0, 29);
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL test_sweep_up %s: got gate=%h idx=%0d sat=%b, want gate=%h idx=%0d sat=%b",
                     t, o.gate, o.idx, o.sat, e.gate, e.idx, e.sat);
         end
      end
   endtask

   task automatic test_sweep_tri_down;
      obs_t e, o;
      string t;
      int tri_seq [7] = '{0, 1, 2, 1, 0, 1, 2};
      int dn_seq  [6] = '{3, 2, 1, 0, 3, 2};
      set_cfg(32'd1, 32'd2, 32'd1, 32'd2, 2, 2, 0, 3, 15);
      frame_type = 2'd0;
      do_reset(0, 2);
      start_frame(2'd1, 0, 0, 1'b0);
      for (int p = 0; p < 6; p++) run_period(tri_seq[p], tri_seq[p+1], 1, 2, 0, 2, 1'b1, 1'b0, 0, 15);
      sweep_mode   = 2'd2;
      tim_cycles_m = 8'd3;
      start_frame(2'd2, 0, 3, 1'b0);
      for (int p = 0; p < 5; p++) run_period(dn_seq[p], dn_seq[p+1], 1, 2, 0, 2, 1'b1, 1'b0, 0, 15);
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL test_sweep_tri_down %s: got gate=%h idx=%0d sat=%b, want gate=%h idx=%0d sat=%b",
                     t, o.gate, o.idx, o.sat, e.gate, e.idx, e.sat);
         end
      end
   endtask

   task automatic test_skew_bg;
      obs_t e, o;
      string t;
      set_cfg(32'd20, 32'd2, 32'd20, 32'd2, 0, 0, 2, 0, 49);
      frame_type = 2'd0;
      do_reset(0, 2);
      start_frame(2'd1, 0, 0, 1'b0);
      run_period(0, 0, 20, 0, 2, 2, 1'b1, 1'b0, 0, 49);
      start_frame(2'd0, 0, 0, 1'b0);
      run_period(0, 0, 20, 0, 2, 2, 1'b0, 1'b0, 0, 49);
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL test_skew_bg %s: got gate=%h idx=%0d sat=%b, want gate=%h idx=%0d sat=%b",
                     t, o.gate, o.idx, o.sat, e.gate, e.idx, e.sat);
         end
      end
   endtask

   task automatic test_saturation;
      obs_t e, o;
      string t;
      set_cfg(32'hFFFF_FFFD, 32'd10, 32'd5, 32'd4, 0, 0, 0, 0, 29);
      frame_type = 2'd0;
      do_reset(0, 2);
      start_frame(2'd1, 0, 0, 1'b1);
      run_period(0, 0, 64'h0000_0000_FFFF_FFFD, 0, 0, 10, 1'b1, 1'b1, 0, 29);
      start_frame(2'd2, 0, 0, 1'b0);
      run_period(0, 0, 5, 0, 0, 4, 1'b1, 1'b0, 0, 29);
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL test_saturation %s: got gate=%h idx=%0d sat=%b, want gate=%h idx=%0d sat=%b",
                     t, o.gate, o.idx, o.sat, e.gate, e.idx, e.sat);
         end
      end
   endtask

   task automatic test_boundary;
      obs_t e, o;
      string t;
      set_cfg(32'd5, 32'd0, 32'd29, 32'd5, 0, 0, 0, 0, 29);
      frame_type = 2'd0;
      do_reset(0, 2);
      start_frame(2'd1, 0, 0, 1'b0);
      run_period(0, 0, 5, 0, 0, 0, 1'b1, 1'b0, 0, 29);
      start_frame(2'd2, 0, 0, 1'b0);
      run_period(0, 0, 29, 0, 0, 5, 1'b1, 1'b0, 0, 29);
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL test_boundary %s: got gate=%h idx=%0d sat=%b, want gate=%h idx=%0d sat=%b",
                     t, o.gate, o.idx, o.sat, e.gate, e.idx, e.sat);
         end
      end
   endtask

   task automatic test_shadow_collision_reset;
      obs_t e, o;
      string t;
      // Mid-frame edits to the live configuration must not move the window or start a sweep.
      set_cfg(32'd10, 32'd3, 32'd25, 32'd10, 2, 1, 0, 0, 29);
      frame_type = 2'd0;
      do_reset(0, 2);
      start_frame(2'd1, 0, 0, 1'b0);
      delay_a    = 32'd2;
      width_a    = 32'd20;
      sweep_mode = 2'd1;
      delay_step = 8'd9;
      repeat (2) run_period(0, 0, 10, 1, 0, 3, 1'b1, 1'b0, 0, 29);
      // Frame change on the hit cycle restarts the sweep and blanks the gate.
      set_cfg(32'd25, 32'd10, 32'd25, 32'd10, 2, 1, 0, 1, 29);
      frame_type = 2'd0;
      do_reset(0, 2);
      start_frame(2'd1, 0, 0, 1'b0);
      run_period(0, 1, 25, 1, 0, 10, 1'b1, 1'b0, 0, 29);
      run_period(1, 1, 25, 1, 0, 10, 1'b1, 1'b0, 0, 28);
      start_frame(2'd2, 29, 0, 1'b0);
      run_period(0, 1, 25, 1, 0, 10, 1'b1, 1'b0, 0, 29);
      // Reset asserted inside an open window.
      run_period(1, 1, 25, 1, 0, 10, 1'b1, 1'b0, 0, 27);
      do_reset(28, 1);
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL test_shadow_collision_reset %s: got gate=%h idx=%0d sat=%b, want gate=%h idx=%0d sat=%b",
                     t, o.gate, o.idx, o.sat, e.gate, e.idx, e.sat);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n        = 1'b0;
      laser_cnt_in = '0;
      frame_type   = 2'd0;
      set_cfg(32'd0, 32'd0, 32'd0, 32'd0, 0, 0, 0, 0, 99);
      @(negedge clk);
      test_reset();
      test_fixed();
      test_sweep_up();
      test_sweep_tri_down();
      test_skew_bg();
      test_saturation();
      test_boundary();
      test_shadow_collision_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
